pipelined_addsub: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshake and ALU-style flags.
- Splits the carry chain into STAGES slices, with one slice resolved per register stage, to meet timing at 64 bits.
- Feeds the execute stage of the core and any multi-cycle arithmetic unit that needs registered add/sub results with backpressure.

---
 rtl/pipelined_addsub.sv | 154 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES slices,
// and each register stage resolves one slice. One global advance signal moves the whole pipe.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // valid must not depend on ready. in_ready is the pipe's advance signal.
  logic             advance;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * SLICE;
      localparam int REM = WIDTH - LO;

      // a_rem/b_rem hold the operand bits that are not yet summed.
      // Their low SLICE bits are the slice this stage resolves.
      logic [REM-1:0]      a_rem, b_rem;
      logic                c_in, v_in;
      logic [SLICE:0]      slice_sum;
      logic [LO+SLICE-1:0] res_new;

      if (k == 0) begin : g_src
        assign a_rem   = a;
        assign b_rem   = b ^ {WIDTH{sub}};
        assign c_in    = cin ^ sub;
        assign v_in    = in_valid && advance;
        assign res_new = slice_sum[SLICE-1:0];
      end else begin : g_src
        assign a_rem   = g_stage[k-1].g_mid.a_q;
        assign b_rem   = g_stage[k-1].g_mid.b_q;
        assign c_in    = g_stage[k-1].g_mid.c_q;
        assign v_in    = g_stage[k-1].g_mid.v_q;
        assign res_new = {slice_sum[SLICE-1:0], g_stage[k-1].g_mid.r_q};
      end

      assign slice_sum = {1'b0, a_rem[SLICE-1:0]} + {1'b0, b_rem[SLICE-1:0]}
                       + {{SLICE{1'b0}}, c_in};

      if (k < STAGES - 1) begin : g_mid
        localparam int NREM = REM - SLICE;

        logic [NREM-1:0]     a_q, a_d, b_q, b_d;
        logic [LO+SLICE-1:0] r_q, r_d;
        logic                c_q, c_d, v_q, v_d;

        always_comb begin
          a_d = a_q;
          b_d = b_q;
          r_d = r_q;
          c_d = c_q;
          v_d = v_q;
          if (advance) begin
            v_d = v_in;
            if (v_in) begin
              a_d = a_rem[REM-1:SLICE];
              b_d = b_rem[REM-1:SLICE];
              r_d = res_new;
              c_d = slice_sum[SLICE];
            end
          end
        end

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            c_q <= c_d;
            v_q <= v_d;
          end
        end
      end else begin : g_last
        logic msb_carry_in;

        // The carry into the MSB is recovered from the MSB sum bit.
        assign msb_carry_in = a_rem[SLICE-1] ^ b_rem[SLICE-1] ^ slice_sum[SLICE-1];

        // Result and flags only load on a valid entry, so a bubble leaves them unchanged.
        always_comb begin
          out_valid_d = out_valid_q;
          out_d       = out_q;
          cout_d      = cout_q;
          overflow_d  = overflow_q;
          zero_d      = zero_q;
          if (advance) begin
            out_valid_d = v_in;
            if (v_in) begin
              out_d      = res_new;
              cout_d     = slice_sum[SLICE];
              overflow_d = msb_carry_in ^ slice_sum[SLICE];
              zero_d     = (res_new == '0);
            end
          end
        end

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
          end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: a 64-bit/4-stage instance, plus 8-bit instances
// with 1 and 8 stages that share the same stimulus.
module tb_pipelined_addsub;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, in_valid, out_ready, cin_i, sub_i;
  logic [63:0] a_i, b_i;
  logic        in_ready, out_valid, cout, overflow, zero;
  logic [63:0] out;
  logic        out_ready_s = 1'b1;
  logic        in_ready_s1, out_valid_s1, cout_s1, overflow_s1, zero_s1;
  logic        in_ready_s8, out_valid_s8, cout_s8, overflow_s8, zero_s8;
  logic [7:0]  out_s1, out_s8;

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .overflow(overflow), .zero(zero));

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_s1),
    .out_ready(out_ready_s), .out(out_s1), .cout(cout_s1), .overflow(overflow_s1),
    .zero(zero_s1));

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s8),
    .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i), .sub(sub_i), .out_valid(out_valid_s8),
    .out_ready(out_ready_s), .out(out_s8), .cout(cout_s8), .overflow(overflow_s8),
    .zero(zero_s8));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] eo;
    logic        ec;
    logic        ev;
    logic        ez;
  } vec_t;

  vec_t        vecs[11];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          stall_cnt = 0;
  int          pop_cyc_q[$];
  logic [66:0] exp_q[$];
  logic [10:0] exp_s1[$];
  logic [10:0] exp_s8[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference results packed as {cout, overflow, zero, out}.
  function automatic logic [66:0] model64(input logic [63:0] av, input logic [63:0] bv,
                                          input logic cv, input logic sv);
    logic [63:0] be;
    logic [64:0] s;
    logic        ovf;
    be  = sv ? ~bv : bv;
    s   = {1'b0, av} + {1'b0, be} + {64'd0, cv ^ sv};
    ovf = (av[63] == be[63]) && (s[63] != av[63]);
    return {s[64], ovf, (s[63:0] == 64'd0), s[63:0]};
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                         input logic cv, input logic sv);
    logic [7:0] be;
    logic [8:0] s;
    logic       ovf;
    be  = sv ? ~bv : bv;
    s   = {1'b0, av} + {1'b0, be} + {8'd0, cv ^ sv};
    ovf = (av[7] == be[7]) && (s[7] != av[7]);
    return {s[8], ovf, (s[7:0] == 8'd0), s[7:0]};
  endfunction

  // 64-bit scoreboard: pop on every completed output handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("w64_spurious_valid", {66'd0, out_valid}, 67'd0);
      else chk("w64_result", {cout, overflow, zero, out}, exp_q.pop_front());
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
    end
  end

  // Small instances: consumer is always ready, expectations pushed on their own accepts.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid_s1) begin
        if (exp_s1.size() == 0) chk("s1_spurious_valid", {66'd0, out_valid_s1}, 67'd0);
        else chk("s1_result", {56'd0, cout_s1, overflow_s1, zero_s1, out_s1},
                 {56'd0, exp_s1.pop_front()});
      end
      if (out_valid_s8) begin
        if (exp_s8.size() == 0) chk("s8_spurious_valid", {66'd0, out_valid_s8}, 67'd0);
        else chk("s8_result", {56'd0, cout_s8, overflow_s8, zero_s8, out_s8},
                 {56'd0, exp_s8.pop_front()});
      end
      if (in_valid && in_ready_s1) exp_s1.push_back(model8(a_i[7:0], b_i[7:0], cin_i, sub_i));
      if (in_valid && in_ready_s8) exp_s8.push_back(model8(a_i[7:0], b_i[7:0], cin_i, sub_i));
    end
  end

  // Present one operation and hold it until the 64-bit instance accepts it.
  task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                       input logic sv, input logic [66:0] ev);
    int n;
    a_i = av; b_i = bv; cin_i = cv; sub_i = sv; in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (n > 0) stall_cnt++;
    if (!in_ready) chk("accept_timeout", {66'd0, in_ready}, 67'd1);
    else exp_q.push_back(ev);
    @(posedge clock);
    #1;
  endtask

  task automatic drive_vec(input int i);
    drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
          {vecs[i].ec, vecs[i].ev, vecs[i].ez, vecs[i].eo});
  endtask

  task automatic drive_rand();
    logic [63:0] av, bv;
    logic        cv, sv;
    av = {$urandom(), $urandom()};
    bv = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) av = '1;
    if ($urandom_range(0, 3) == 0) bv = 64'd1;
    cv = 1'($urandom_range(0, 1));
    sv = 1'($urandom_range(0, 1));
    drive(av, bv, cv, sv, model64(av, bv, cv, sv));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() + exp_s1.size() + exp_s8.size()) != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", 67'(exp_q.size() + exp_s1.size() + exp_s8.size()), 67'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat64, lat_s1, lat_s8, stall0, p0, seen, spacing;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{64'd5, 64'd5, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{64'd5, 64'd3, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                 64'd0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{64'h80, 64'd1, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b0, 1'b0};

    // Outputs while reset is asserted.
    repeat (2) @(negedge clock);
    chk("rst_out_valid", {66'd0, out_valid}, 67'd0);
    chk("rst_out", {3'd0, out}, 67'd0);
    chk("rst_flags", {64'd0, cout, overflow, zero}, 67'd0);
    chk("rst_in_ready", {66'd0, in_ready}, 67'd1);
    chk("rst_small", {48'd0, out_valid_s1, out_valid_s8, cout_s1, cout_s8, out_s1, out_s8},
        67'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // A single operation, to measure latency on each instance.
    drive_vec(0);
    in_valid = 1'b0;
    lat64 = 0; lat_s1 = 0; lat_s8 = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clock);
      if (out_valid && lat64 == 0) lat64 = j;
      if (out_valid_s1 && lat_s1 == 0) lat_s1 = j;
      if (out_valid_s8 && lat_s8 == 0) lat_s8 = j;
    end
    chk("latency_w64_s4", 67'(lat64), 67'd4);
    chk("latency_w8_s1", 67'(lat_s1), 67'd1);
    chk("latency_w8_s8", 67'(lat_s8), 67'd8);
    @(posedge clock);
    #1;

    // Table vectors applied back to back.
    stall0 = stall_cnt;
    for (int i = 0; i < 11; i++) drive_vec(i);
    in_valid = 1'b0;
    wait_drain();
    chk("table_no_stall", 67'(stall_cnt - stall0), 67'd0);

    // Stream of 16 random operations: one result per cycle.
    pop_cyc_q.delete();
    stall0 = stall_cnt;
    for (int i = 0; i < 16; i++) drive_rand();
    in_valid = 1'b0;
    wait_drain();
    chk("stream_no_stall", 67'(stall_cnt - stall0), 67'd0);
    chk("stream_count", 67'(pop_cyc_q.size()), 67'd16);
    spacing = (pop_cyc_q.size() == 16) ? (pop_cyc_q[15] - pop_cyc_q[0]) : -1;
    chk("stream_spacing", 67'(spacing), 67'd15);

    // Backpressure: fill the pipe, then hold out_ready low while a fifth op waits.
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) drive_rand();
    fork
      drive_rand();
      begin
        @(negedge clock);
        chk("bp_full", {65'd0, out_valid, in_ready}, 67'b10);
        for (int j = 0; j < 5; j++) begin
          @(negedge clock);
          chk("bp_in_ready", {66'd0, in_ready}, 67'd0);
          chk("bp_hold", {cout, overflow, zero, out}, exp_q.size() > 0 ? exp_q[0] : '1);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    wait_drain();
    chk("bp_pop_count", 67'(pop_cnt - p0), 67'd5);

    // Reset while three operations are in flight.
    for (int i = 0; i < 3; i++) drive_rand();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", {64'd0, out_valid, out_valid_s1, out_valid_s8}, 67'd0);
    chk("rst_mid_out", {cout, overflow, zero, out}, 67'd0);
    chk("rst_mid_small", {51'd0, out_s1, out_s8}, 67'd0);
    exp_q.delete();
    exp_s1.delete();
    exp_s8.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid || out_valid_s1 || out_valid_s8) seen++;
    end
    chk("rst_no_ghost", 67'(seen), 67'd0);

    // The pipe works normally again after reset.
    @(posedge clock);
    #1;
    drive_vec(1);
    drive_vec(10);
    in_valid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
